// File: rtl/down_counter_tmr_pkg.sv
// Shared definitions for the loadable down-counter/timer.
// COND_IDLE is also used by the 2-bit condition-gated up counter.
package down_counter_tmr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   localparam logic [1:0] COND_IDLE = 2'b00;

endpackage

// File: rtl/down_counter_tmr.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// All outputs decode from registered state/count only.
module down_counter_tmr
   import down_counter_tmr_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [1:0]       condition,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             cond_on;

   assign cond_on = (condition != COND_IDLE);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      if (load) begin
         // A load overrides decrement, hold and any pending reload.
         count_d  = load_val;
         reload_d = load_val;
         state_d  = (load_val == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN, ST_HOLD: begin
               if (cond_on) begin
                  state_d = ST_RUN;
                  if (count_q == ONE) begin
                     count_d = '0;
                     state_d = ST_DONE;
                  end else begin
                     count_d = count_q - ONE;
                  end
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_DONE: begin
               if (AUTO_RELOAD && (reload_q != '0)) begin
                  count_d = reload_q;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count  = count_q;
   assign busy   = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign paused = (state_q == ST_HOLD);
   assign done   = (state_q == ST_DONE);

endmodule
